// File: rtl/split_radio_pkg.sv
// Shared encodings for the split-radio scheduler: destination tags,
// FSM states and the default credit ceiling.
package split_radio_pkg;

    localparam logic DEST_RADIO = 1'b0;
    localparam logic DEST_WIRED = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CREDIT_MAX_DEF = 4;

endpackage

// File: rtl/split_radio_credit.sv
// Per-consumer credit counter with a sticky overflow flag raised when a
// credit return arrives while the counter already sits at its ceiling.
module split_radio_credit
    import split_radio_pkg::*;
#(
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CREDIT_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                take,
    input  logic                give,
    output logic [CREDIT_W-1:0] credit,
    output logic                error
);

    localparam logic [CREDIT_W-1:0] MAX = CREDIT_W'(CREDIT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit <= MAX;
            error  <= 1'b0;
        end else if (take && !give) begin
            credit <= credit - 1'b1;
        end else if (give && !take) begin
            if (credit == MAX) error <= 1'b1;
            else credit <= credit + 1'b1;
        end
    end

endmodule

// File: rtl/split_radio_scheduler.sv
// Credit-gated round-robin steering of Receive words to Radio/Wired through
// a fixed-latency fetch pipeline. SPLIT_RADIO_STATS_EN adds delivery counters.
module split_radio_scheduler
    import split_radio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int STAGES     = 3,
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CREDIT_W   = 3
) (
    input  logic              Clock,
    input  logic              Reset_N,
    input  logic              Enable,
    input  logic              Receive_Valid,
    input  logic [DATA_W-1:0] Receive_Data,
    output logic              Receive_Ready,
    input  logic              Radio_Req,
    input  logic              Wired_Req,
    output logic              Radio_Valid,
    output logic [DATA_W-1:0] Radio_Data,
    output logic              Wired_Valid,
    output logic [DATA_W-1:0] Wired_Data,
    input  logic              Radio_Credit_Return,
    input  logic              Wired_Credit_Return,
    output logic              Busy,
`ifdef SPLIT_RADIO_STATS_EN
    output logic [15:0]       Radio_Count,
    output logic [15:0]       Wired_Count,
`endif
    output logic              Credit_Error
);

    localparam int PD = (STAGES > 1) ? STAGES - 1 : 1;

    state_t state, state_nx;

    logic [CREDIT_W-1:0] credit_r, credit_w;
    logic                err_r, err_w;
    logic                elig_r, elig_w;
    logic                accept, grant, last;
    logic                take_r, take_w;

    logic [STAGES-1:0]   pv;
    logic                pt [STAGES];
    logic [DATA_W-1:0]   pd [PD];
    logic                feed_v, feed_t;
    logic [DATA_W-1:0]   feed_d;

    assign elig_r = Radio_Req && (credit_r != '0);
    assign elig_w = Wired_Req && (credit_w != '0);
    assign grant  = elig_r ? ((elig_w && last == DEST_RADIO) ? DEST_WIRED
                                                             : DEST_RADIO)
                           : DEST_WIRED;
    assign accept = Receive_Valid && Receive_Ready;
    assign take_r = accept && (grant == DEST_RADIO);
    assign take_w = accept && (grant == DEST_WIRED);

    split_radio_credit #(
        .CREDIT_MAX(CREDIT_MAX),
        .CREDIT_W  (CREDIT_W)
    ) u_credit_radio (
        .clk   (Clock),
        .rst_n (Reset_N),
        .take  (take_r),
        .give  (Radio_Credit_Return),
        .credit(credit_r),
        .error (err_r)
    );

    split_radio_credit #(
        .CREDIT_MAX(CREDIT_MAX),
        .CREDIT_W  (CREDIT_W)
    ) u_credit_wired (
        .clk   (Clock),
        .rst_n (Reset_N),
        .take  (take_w),
        .give  (Wired_Credit_Return),
        .credit(credit_w),
        .error (err_w)
    );

    assign Credit_Error = err_r || err_w;

    always_ff @(posedge Clock) begin
        if (!Reset_N) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (Enable) state_nx = RUN;
            RUN:     if (!Enable) state_nx = DRAIN;
            DRAIN: begin
                if (Enable) state_nx = RUN;
                else if (pv == '0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Receive_Ready = (state == RUN) && (elig_r || elig_w);
        Busy          = (state != IDLE) || (pv != '0);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            pv   <= '0;
            last <= DEST_WIRED;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < STAGES; i++) pv[i] <= pv[i-1];
            if (accept) last <= grant;
        end
    end

    // Tags and data need no reset: the valid bits qualify them.
    always_ff @(posedge Clock) begin
        pt[0] <= grant;
        pd[0] <= Receive_Data;
        for (int i = 1; i < STAGES; i++) pt[i] <= pt[i-1];
        for (int i = 1; i < PD; i++) pd[i] <= pd[i-1];
    end

    // The last stage is split into per-side data registers so each output
    // holds its own last delivered word.
    generate
        if (STAGES == 1) begin : g_feed_direct
            assign feed_v = accept;
            assign feed_t = grant;
            assign feed_d = Receive_Data;
        end else begin : g_feed_pipe
            assign feed_v = pv[STAGES-2];
            assign feed_t = pt[STAGES-2];
            assign feed_d = pd[PD-1];
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            Radio_Data <= '0;
            Wired_Data <= '0;
        end else if (feed_v) begin
            if (feed_t == DEST_RADIO) Radio_Data <= feed_d;
            else Wired_Data <= feed_d;
        end
    end

    assign Radio_Valid = pv[STAGES-1] && (pt[STAGES-1] == DEST_RADIO);
    assign Wired_Valid = pv[STAGES-1] && (pt[STAGES-1] == DEST_WIRED);

`ifdef SPLIT_RADIO_STATS_EN
    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            Radio_Count <= '0;
            Wired_Count <= '0;
        end else begin
            if (Radio_Valid) Radio_Count <= Radio_Count + 16'd1;
            if (Wired_Valid) Wired_Count <= Wired_Count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_split_radio_scheduler.sv
// Randomized bench for split_radio_scheduler against a queue-based model;
// SPLIT_RADIO_STATS_EN also checks the delivery counters.
module tb_split_radio_scheduler;

    localparam int DW = 8;
    localparam int ST = 3;
    localparam int CM = 4;

    logic          clk = 1'b0;
    logic          Reset_N, Enable, Receive_Valid, Receive_Ready;
    logic [DW-1:0] Receive_Data, Radio_Data, Wired_Data;
    logic          Radio_Req, Wired_Req, Radio_Valid, Wired_Valid;
    logic          Radio_Credit_Return, Wired_Credit_Return;
    logic          Busy, Credit_Error;
`ifdef SPLIT_RADIO_STATS_EN
    logic [15:0]   Radio_Count, Wired_Count;
`endif

    always #5 clk = ~clk;

    split_radio_scheduler #(
        .DATA_W(DW), .STAGES(ST), .CREDIT_MAX(CM), .CREDIT_W(3)
    ) dut (
        .Clock              (clk),
        .Reset_N            (Reset_N),
        .Enable             (Enable),
        .Receive_Valid      (Receive_Valid),
        .Receive_Data       (Receive_Data),
        .Receive_Ready      (Receive_Ready),
        .Radio_Req          (Radio_Req),
        .Wired_Req          (Wired_Req),
        .Radio_Valid        (Radio_Valid),
        .Radio_Data         (Radio_Data),
        .Wired_Valid        (Wired_Valid),
        .Wired_Data         (Wired_Data),
        .Radio_Credit_Return(Radio_Credit_Return),
        .Wired_Credit_Return(Wired_Credit_Return),
        .Busy               (Busy),
`ifdef SPLIT_RADIO_STATS_EN
        .Radio_Count        (Radio_Count),
        .Wired_Count        (Wired_Count),
`endif
        .Credit_Error       (Credit_Error)
    );

    typedef struct {
        int          due;
        bit          wired;
        logic [7:0]  data;
    } item_t;

    item_t      q[$];
    int         m_state;
    int         cr, cw;
    bit         last_wired, err;
    logic [7:0] rd, wd;
    int         cnt_r, cnt_w;
    int         cur;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        cr         = CM;
        cw         = CM;
        last_wired = 1'b1;
        err        = 1'b0;
        rd         = '0;
        wd         = '0;
        cnt_r      = 0;
        cnt_w      = 0;
        q.delete();
    endtask

    initial begin
        bit vr, vw, pipe_busy, er, ew, rdy, acc, g, tr, tw;
        Reset_N = 1'b0;
        Enable = 1'b1;
        Receive_Valid = 1'b0;
        Receive_Data = '0;
        Radio_Req = 1'b0;
        Wired_Req = 1'b0;
        Radio_Credit_Return = 1'b0;
        Wired_Credit_Return = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        cur = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            Reset_N = (n < 1) ? 1'b0 : ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) Enable = ~Enable;
            Receive_Valid = ($urandom_range(0, 3) != 0);
            Receive_Data = 8'($urandom);
            Radio_Req = ($urandom_range(0, 4) != 0);
            Wired_Req = ($urandom_range(0, 4) != 0);
            Radio_Credit_Return = ($urandom_range(0, 5) == 0);
            Wired_Credit_Return = ($urandom_range(0, 5) == 0);
            #1;
            vr = 0;
            vw = 0;
            if (q.size() > 0 && q[0].due == cur) begin
                vr = !q[0].wired;
                vw = q[0].wired;
                if (vr) rd = q[0].data;
                else wd = q[0].data;
            end
            pipe_busy = (q.size() != 0);
            if (vr || vw) void'(q.pop_front());
            er  = Radio_Req && cr > 0;
            ew  = Wired_Req && cw > 0;
            rdy = (m_state == 1) && (er || ew);
            check("ready", 32'(Receive_Ready), 32'(rdy));
            check("busy", 32'(Busy), 32'(m_state != 0 || pipe_busy));
            check("radio_valid", 32'(Radio_Valid), 32'(vr));
            check("wired_valid", 32'(Wired_Valid), 32'(vw));
            check("radio_data", 32'(Radio_Data), 32'(rd));
            check("wired_data", 32'(Wired_Data), 32'(wd));
            check("credit_error", 32'(Credit_Error), 32'(err));
`ifdef SPLIT_RADIO_STATS_EN
            check("radio_count", 32'(Radio_Count), 32'(cnt_r));
            check("wired_count", 32'(Wired_Count), 32'(cnt_w));
`endif
            if (!Reset_N) begin
                model_reset();
            end else begin
                acc = Receive_Valid && rdy;
                g = er ? (ew && !last_wired) : 1'b1;
                if (acc) begin
                    q.push_back('{due: cur + ST, wired: g, data: Receive_Data});
                    last_wired = g;
                end
                tr = acc && !g;
                tw = acc && g;
                if (tr && !Radio_Credit_Return) cr--;
                else if (Radio_Credit_Return && !tr) begin
                    if (cr == CM) err = 1'b1;
                    else cr++;
                end
                if (tw && !Wired_Credit_Return) cw--;
                else if (Wired_Credit_Return && !tw) begin
                    if (cw == CM) err = 1'b1;
                    else cw++;
                end
                if (vr) cnt_r = (cnt_r + 1) & 16'hFFFF;
                if (vw) cnt_w = (cnt_w + 1) & 16'hFFFF;
                case (m_state)
                    0: if (Enable) m_state = 1;
                    1: if (!Enable) m_state = 2;
                    default: begin
                        if (Enable) m_state = 1;
                        else if (!pipe_busy) m_state = 0;
                    end
                endcase
            end
            cur++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
